alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 37 +++
 rtl/alu_issue_alu.sv | 33 +++
 rtl/alu_issue.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for alu_issue: opcode constants, FSM state encoding and
// an opcode-validity helper used by the alu.
package alu_issue_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_MPY = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_OR  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_XOR = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SHL = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SRL = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_SRA = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
`ifdef ALU_ITER_MPY_EN
        ,
        ST_MUL  = 2'd3
`endif
    } state_t;

    function automatic logic op_defined(input logic [OPCODE_W-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SRL, OP_SRA: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational alu: result is the low DATA_W bits of the operation; undefined
// opcodes give err=1 with a zero result. Shift amounts are used unclamped.
import alu_issue_pkg::*;

module alu_issue_alu #(
    parameter int DATA_W = 32
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result,
    output logic                err
);

    always_comb begin
        result = '0;
        err    = ~op_defined(opcode);
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MPY:  result = a * b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b;
            OP_SRL:  result = a >> b;
            // Shift counts of DATA_W or more fill entirely with the sign bit.
            OP_SRA:  result = $signed(a) >>> b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single-command issue wrapper around the alu with valid/ready request and
// response ports. Define ALU_ITER_MPY_EN to run MPY on an inline shift-add iterator.
import alu_issue_pkg::*;

module alu_issue #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPCODE_W-1:0] req_opcode,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [1:0]          fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; once raised, rsp_valid and its payload hold until accepted.

    state_t state, state_next;

    logic [OPCODE_W-1:0] op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic                err_q;
    logic                exec_stage;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_err;
    logic [DATA_W-1:0]   exec_result;

    alu_issue_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .err    (alu_err)
    );

`ifdef ALU_ITER_MPY_EN
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;
    logic [CNT_W-1:0]  mul_cnt;
    logic              mul_last;

    assign mul_last = (mul_cnt == CNT_W'(DATA_W - 1));

    // One multiplier bit per cycle; only the low DATA_W product bits are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            mul_acc    <= '0;
            mul_mcand  <= req_a;
            mul_mplier <= req_b;
            mul_cnt    <= '0;
        end else if (state == ST_MUL) begin
            if (mul_mplier[0]) begin
                mul_acc <= mul_acc + mul_mcand;
            end
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        exec_result = alu_result;
`ifdef ALU_ITER_MPY_EN
        if (op_q == OP_MPY) begin
            exec_result = mul_acc;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef ALU_ITER_MPY_EN
                    state_next = (req_opcode == OP_MPY) ? ST_MUL : ST_EXEC;
`else
                    state_next = ST_EXEC;
`endif
                end
            end
`ifdef ALU_ITER_MPY_EN
            ST_MUL: begin
                if (mul_last) begin
                    state_next = ST_EXEC;
                end
            end
`endif
            ST_EXEC: begin
                if (exec_stage) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        if (state == ST_IDLE) begin
            req_ready = 1'b1;
        end
        if (state == ST_RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // EXEC spends two cycles: the first registers the alu output, the second
    // moves it into the response registers, so the alu path ends in a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            exec_stage <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_opcode;
                        a_q        <= req_a;
                        b_q        <= req_b;
                        exec_stage <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (!exec_stage) begin
                        res_q      <= exec_result;
                        err_q      <= alu_err;
                        exec_stage <= 1'b1;
                    end else begin
                        rsp_data_q <= res_q;
                        rsp_err_q  <= err_q;
                        exec_stage <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, arithmetic/logic/shift results, latency,
// back-pressure, undefined opcodes and mid-command reset.
import alu_issue_pkg::*;

module tb_alu_issue;

    localparam int DATA_W = 32;
`ifdef ALU_ITER_MPY_EN
    localparam int MPY_LAT = DATA_W + 2;
`else
    localparam int MPY_LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [OPCODE_W-1:0] req_opcode = '0;
    logic [DATA_W-1:0]   req_a = '0;
    logic [DATA_W-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic [1:0]          fsm_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_issue #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .fsm_state  (fsm_state)
    );

    // Drives one command from IDLE and returns cycles from accept edge to rsp_valid.
    task automatic send_cmd(input logic [OPCODE_W-1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, output int lat,
                            output logic [DATA_W-1:0] data, output logic err);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data;
        err  = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_data !== '0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else pass_cnt++;
        total_cnt++; if (fsm_state !== 2'd0) $display("FAIL reset_state got %0d want 0", fsm_state); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        send_cmd(OP_ADD, 32'd1, 32'd5, lat, d, e);
        total_cnt++; if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (d !== 32'd6) $display("FAIL add_data got %h want 6", d); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL add_err got %b want 0", e); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL add_busy_ready got %b want 0", req_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL add_valid_drop got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL add_ready_back got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [OPCODE_W-1:0] ops [12];
        logic [DATA_W-1:0]   va  [12];
        logic [DATA_W-1:0]   vb  [12];
        logic [DATA_W-1:0]   exp [12];
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        ops[0]  = OP_SUB; va[0]  = 32'd0;          vb[0]  = 32'd3;   exp[0]  = 32'hFFFF_FFFD;
        ops[1]  = OP_ADD; va[1]  = 32'hFFFF_FFFF;  vb[1]  = 32'd1;   exp[1]  = 32'h0;
        ops[2]  = OP_AND; va[2]  = 32'hF0F0_1234;  vb[2]  = 32'h0FF0_00FF; exp[2] = 32'h00F0_0034;
        ops[3]  = OP_OR;  va[3]  = 32'hA000_0005;  vb[3]  = 32'h0500_0030; exp[3] = 32'hA500_0035;
        ops[4]  = OP_XOR; va[4]  = 32'hFFFF_0000;  vb[4]  = 32'h0F0F_0F0F; exp[4] = 32'hF0F0_0F0F;
        ops[5]  = OP_SHL; va[5]  = 32'd1;          vb[5]  = 32'd4;   exp[5]  = 32'd16;
        ops[6]  = OP_SHL; va[6]  = 32'hFFFF_FFFF;  vb[6]  = 32'd255; exp[6]  = 32'h0;
        ops[7]  = OP_SRL; va[7]  = 32'h8000_0000;  vb[7]  = 32'd31;  exp[7]  = 32'd1;
        ops[8]  = OP_SRL; va[8]  = 32'hFFFF_FFFF;  vb[8]  = 32'd255; exp[8]  = 32'h0;
        ops[9]  = OP_SRA; va[9]  = 32'h8000_0000;  vb[9]  = 32'd4;   exp[9]  = 32'hF800_0000;
        ops[10] = OP_SRA; va[10] = 32'h8000_0000;  vb[10] = 32'd255; exp[10] = 32'hFFFF_FFFF;
        ops[11] = OP_SRA; va[11] = 32'h4000_0000;  vb[11] = 32'd30;  exp[11] = 32'd1;
        for (int i = 0; i < 12; i++) begin
            send_cmd(ops[i], va[i], vb[i], lat, d, e);
            total_cnt++; if (d !== exp[i] || e !== 1'b0 || lat !== 2)
                $display("FAIL vector_%0d got data=%h err=%b lat=%0d want data=%h err=0 lat=2", i, d, e, lat, exp[i]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mpy();
        logic [DATA_W-1:0] ma  [3];
        logic [DATA_W-1:0] mb  [3];
        logic [DATA_W-1:0] exp [3];
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        ma[0] = 32'd8;          mb[0] = 32'd7;       exp[0] = 32'd56;
        ma[1] = 32'hFFFF_FFFF;  mb[1] = 32'd2;       exp[1] = 32'hFFFF_FFFE;
        ma[2] = 32'h0001_0000;  mb[2] = 32'h0001_0003; exp[2] = 32'h0003_0000;
        for (int i = 0; i < 3; i++) begin
            send_cmd(OP_MPY, ma[i], mb[i], lat, d, e);
            total_cnt++; if (d !== exp[i]) $display("FAIL mpy_data_%0d got %h want %h", i, d, exp[i]); else pass_cnt++;
            total_cnt++; if (lat !== MPY_LAT) $display("FAIL mpy_latency_%0d got %0d want %0d", i, lat, MPY_LAT); else pass_cnt++;
            total_cnt++; if (e !== 1'b0) $display("FAIL mpy_err_%0d got %b want 0", i, e); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        rsp_ready = 1'b0;
        send_cmd(OP_AND, 32'd18, 32'd7, lat, d, e);
        total_cnt++; if (d !== 32'd2 || lat !== 2) $display("FAIL bp_first got data=%h lat=%0d want data=2 lat=2", d, lat); else pass_cnt++;
        req_valid  = 1'b1;
        req_opcode = OP_ADD;
        req_a      = 32'd100;
        req_b      = 32'd100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || req_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b want valid=1 data=2 ready=0", i, rsp_valid, rsp_data, req_ready);
            else pass_cnt++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got valid=%b want 0", rsp_valid); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (rsp_valid !== 1'b0 || fsm_state !== 2'd0)
            $display("FAIL bp_no_second got valid=%b state=%0d want valid=0 state=0", rsp_valid, fsm_state);
        else pass_cnt++;
    endtask

    task automatic test_undefined();
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        send_cmd(5'h1F, 32'd5, 32'd6, lat, d, e);
        total_cnt++; if (e !== 1'b1) $display("FAIL undef_err got %b want 1", e); else pass_cnt++;
        total_cnt++; if (d !== '0) $display("FAIL undef_data got %h want 0", d); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL undef_latency got %0d want 2", lat); else pass_cnt++;
        @(posedge clk); #1;
        send_cmd(OP_ADD, 32'd2, 32'd3, lat, d, e);
        total_cnt++; if (d !== 32'd5 || e !== 1'b0) $display("FAIL undef_next got data=%h err=%b want data=5 err=0", d, e); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [OPCODE_W-1:0] aop [2];
        int lat;
        logic [DATA_W-1:0] d;
        logic e;
        aop[0] = OP_ADD;
        aop[1] = OP_MPY;
        for (int i = 0; i < 2; i++) begin
            req_valid  = 1'b1;
            req_opcode = aop[i];
            req_a      = 32'd9;
            req_b      = 32'd9;
            @(posedge clk); #1;
            req_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            total_cnt++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== '0 || rsp_err !== 1'b0)
                $display("FAIL abort_exec_%0d got valid=%b ready=%b data=%h err=%b want 0 1 0 0", i, rsp_valid, req_ready, rsp_data, rsp_err);
            else pass_cnt++;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL abort_quiet_%0d_%0d got valid=%b want 0", i, k, rsp_valid); else pass_cnt++;
            end
        end
        rsp_ready = 1'b0;
        send_cmd(OP_ADD, 32'd7, 32'd8, lat, d, e);
        total_cnt++; if (d !== 32'd15) $display("FAIL abort_resp_setup got %h want f", d); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        total_cnt++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || req_ready !== 1'b1)
            $display("FAIL abort_resp got valid=%b data=%h ready=%b want 0 0 1", rsp_valid, rsp_data, req_ready);
        else pass_cnt++;
        send_cmd(OP_SUB, 32'd10, 32'd4, lat, d, e);
        total_cnt++; if (d !== 32'd6 || lat !== 2) $display("FAIL abort_recover got data=%h lat=%0d want 6 2", d, lat); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_vectors();
        test_mpy();
        test_backpressure();
        test_undefined();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
